// File: rtl/store_merge_ctrl.sv
// store_merge_ctrl: store controller; word stores write directly, byte/half stores read-modify-write
module store_merge_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  store_size,
   input  logic [31:0] addr,
   input  logic [31:0] B_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        align_exc
);
   typedef enum logic [2:0] {IDLE, READ, WAIT, MERGE, WRITE, DONE, EXC} state_t;
   state_t      state, state_n;
   logic [31:0] addr_q, b_q, rdata_q, merged;
   logic [1:0]  size_q;
   logic        bad;
   assign bad = (store_size == 2'b11) || (store_size == 2'b00 && addr[1:0] != 2'b00) ||
                (store_size == 2'b01 && addr[0]);
   // state register, operand capture on acceptance, read word capture at the end of MERGE
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         b_q     <= '0;
         size_q  <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && start) begin
            addr_q <= addr;
            b_q    <= B_data;
            size_q <= store_size;
         end
         if (state == MERGE) rdata_q <= mem_rdata;
      end
   end
   // replace the addressed byte or half lane of the registered read word
   always_comb begin
      merged = rdata_q;
      if (size_q == 2'b01) merged[{addr_q[1], 4'b0} +: 16] = b_q[15:0];
      else merged[{addr_q[1:0], 3'b0} +: 8] = b_q[7:0];
   end
   // next state and state-decoded outputs
   always_comb begin
      state_n   = state;
      mem_addr  = '0;
      mem_wr    = 1'b0;
      mem_wdata = '0;
      busy      = state != IDLE;
      done      = 1'b0;
      align_exc = 1'b0;
      case (state)
         IDLE:  if (start) state_n = bad ? EXC : (store_size == 2'b00 ? WRITE : READ);
         READ:  begin
            state_n  = WAIT;
            mem_addr = {addr_q[31:2], 2'b00};
         end
         WAIT:  begin
            state_n  = MERGE;
            mem_addr = {addr_q[31:2], 2'b00};
         end
         MERGE: begin
            state_n  = WRITE;
            mem_addr = {addr_q[31:2], 2'b00};
         end
         WRITE: begin
            state_n   = DONE;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wr    = 1'b1;
            mem_wdata = size_q == 2'b00 ? b_q : merged;
         end
         DONE:  begin
            state_n = IDLE;
            done    = 1'b1;
         end
         EXC:   begin
            state_n   = IDLE;
            align_exc = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
